// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and sequencer for the shared data-memory port.
// A grant latches the winner's request; the transaction then runs a fixed
// ACCESS -> WAIT -> DONE sequence before the arbiter returns to IDLE.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  owner
);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StWait,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic                  grant;
   logic                  winner;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  owner_q;
   logic                  last_q;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;

   // Next-state and arbitration: only IDLE looks at the requests.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      winner  = owner_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               grant   = 1'b1;
               // On a tie the requester that was not served last wins.
               winner  = (req0 && req1) ? ~last_q : req1;
               state_d = StAccess;
            end
         end
         StAccess: state_d = StWait;
         StWait:   state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the winning request at grant; these also drive the memory port.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else if (grant) begin
         we_q    <= winner ? we1 : we0;
         addr_q  <= winner ? addr1 : addr0;
         wdata_q <= winner ? wdata1 : wdata0;
         owner_q <= winner;
         last_q  <= winner;
      end
   end

   // Capture read data at the edge closing WAIT, for the owning requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state_q == StWait && !we_q) begin
         if (owner_q) begin
            rdata1_q <= mem_rdata;
         end else begin
            rdata0_q <= mem_rdata;
         end
      end
   end

   // Output decode from the registered state.
   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_write = (state_q == StAccess) && we_q;
      busy      = (state_q != StIdle);
      owner     = owner_q;
      ack0      = (state_q == StDone) && !owner_q;
      ack1      = (state_q == StDone) && owner_q;
      rdata0    = rdata0_q;
      rdata1    = rdata1_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single transactions,
// hand-written multi-cycle sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [11:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [15:0] rdata0, rdata1;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_write;
   logic [15:0] mem_rdata;
   logic        busy, owner;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Memory environment: 16-bit words at even byte addresses.
   logic [15:0] mem [0:2047];
   initial for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
   always @(posedge clk) if (mem_write) mem[mem_addr[11:1]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[11:1]];

   // Reference model: tracks the transaction in flight by its age in cycles
   // since grant (-1 = no transaction) and commits effects from the rules.
   int          m_age = -1;
   logic        m_we = 1'b0, m_owner = 1'b0, m_last = 1'b1;
   logic [11:0] m_addr = '0;
   logic [15:0] m_wdata = '0, m_pend = '0, m_rdata0 = '0, m_rdata1 = '0;
   logic [15:0] m_mem [0:2047];
   initial for (int i = 0; i < 2048; i++) m_mem[i] = 16'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic w;
      if (reset) begin
         m_age = -1; m_we = 1'b0; m_owner = 1'b0; m_last = 1'b1;
         m_addr = '0; m_wdata = '0; m_rdata0 = '0; m_rdata1 = '0;
      end else if (m_age < 0) begin
         if (req0 || req1) begin
            w       = (req0 && req1) ? ~m_last : req1;
            m_owner = w;
            m_last  = w;
            m_we    = w ? we1 : we0;
            m_addr  = w ? addr1 : addr0;
            m_wdata = w ? wdata1 : wdata0;
            // A granted write always reaches memory: its only write cycle
            // ends on the very next edge, which a reset cannot suppress.
            if (m_we) m_mem[m_addr[11:1]] = m_wdata;
            else      m_pend = m_mem[m_addr[11:1]];
            m_age = 1;
         end
      end else if (m_age == 2) begin
         if (!m_we) begin
            if (m_owner) m_rdata1 = m_pend;
            else         m_rdata0 = m_pend;
         end
         m_age = 3;
      end else if (m_age == 3) begin
         m_age = -1;
      end else begin
         m_age = m_age + 1;
      end
   endtask

   task automatic check_outputs();
      chk("busy", busy, m_age >= 0);
      chk("ack0", ack0, m_age == 3 && !m_owner);
      chk("ack1", ack1, m_age == 3 && m_owner);
      chk("mem_write", mem_write, m_age == 1 && m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("owner", owner, m_owner);
      chk("rdata0", rdata0, m_rdata0);
      chk("rdata1", rdata1, m_rdata1);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic set_req(input bit who, input bit r, input bit we,
                          input logic [11:0] a, input logic [15:0] d);
      if (who) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
      else     begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
   endtask

   typedef struct {
      bit          who;
      bit          we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int          lat, nwr, k, t0, t1, nack;
      bit          got;
      logic [15:0] old;
      bit          order[$];

      vecs[0] = '{1'b0, 1'b1, 12'hFFE, 16'hAAAA, 16'h0};
      vecs[1] = '{1'b0, 1'b0, 12'hFFE, 16'h0,    16'hAAAA};
      vecs[2] = '{1'b1, 1'b1, 12'h000, 16'h1234, 16'h0};
      vecs[3] = '{1'b1, 1'b0, 12'h000, 16'h0,    16'h1234};
      vecs[4] = '{1'b1, 1'b0, 12'hFFE, 16'h0,    16'hAAAA};
      vecs[5] = '{1'b0, 1'b1, 12'hFFC, 16'hC0DE, 16'h0};
      vecs[6] = '{1'b1, 1'b1, 12'hFFA, 16'hBEEF, 16'h0};
      vecs[7] = '{1'b0, 1'b0, 12'hFFC, 16'h0,    16'hC0DE};
      vecs[8] = '{1'b1, 1'b1, 12'h7FF, 16'h5555, 16'h0};
      vecs[9] = '{1'b0, 1'b0, 12'h7FE, 16'h0,    16'h5555};

      reset = 1'b1;
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Table-driven single transactions.
      for (int v = 0; v < 10; v++) begin
         set_req(vecs[v].who, 1, vecs[v].we, vecs[v].addr, vecs[v].wdata);
         lat = 0; nwr = 0; got = 0;
         for (int i = 0; i < 10 && !got; i++) begin
            tick();
            lat++;
            if (mem_write) begin
               nwr++;
               chk("vec_write_addr", mem_addr, vecs[v].addr);
            end
            if (vecs[v].who ? ack1 : ack0) got = 1;
         end
         set_req(vecs[v].who, 0, 0, '0, '0);
         chk("vec_ack_seen", got, 1);
         chk("vec_latency", lat, 3);
         chk("vec_write_cycles", nwr, vecs[v].we ? 1 : 0);
         if (!vecs[v].we)
            chk("vec_rdata", vecs[v].who ? rdata1 : rdata0, vecs[v].exp_rdata);
         tick();
      end

      // Simultaneous reads after reset: requester 0 wins the first tie.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_req(0, 1, 0, 12'hFFC, '0);
      set_req(1, 1, 0, 12'hFFA, '0);
      t0 = -1; t1 = -1;
      for (int i = 1; i <= 12 && t1 < 0; i++) begin
         tick();
         if (ack0) begin
            t0 = i;
            chk("sim_owner0", owner, 0);
            chk("sim_rdata0", rdata0, 16'hC0DE);
            req0 = 1'b0;
         end
         if (ack1) begin
            t1 = i;
            chk("sim_owner1", owner, 1);
            chk("sim_rdata1", rdata1, 16'hBEEF);
            req1 = 1'b0;
         end
      end
      chk("sim_ack0_time", t0, 3);
      chk("sim_ack1_time", t1, 7);
      tick();

      // Sustained contention: both requesters held for eight transactions.
      set_req(0, 1, 0, 12'h010, '0);
      set_req(1, 1, 0, 12'h020, '0);
      for (int i = 0; i < 40 && order.size() < 8; i++) begin
         tick();
         if (ack0) order.push_back(1'b0);
         if (ack1) order.push_back(1'b1);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("contention_count", order.size(), 8);
      k = 0;
      foreach (order[j]) begin
         chk("contention_order", order[j], k[0]);
         k++;
      end

      // Reset during the ACCESS cycle of a write.
      old = mem[12'hFF8 >> 1];
      set_req(0, 1, 1, 12'hFF8, 16'hBBBB);
      got = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         tick();
         if (mem_write) got = 1;
      end
      chk("rst_access_seen", got, 1);
      reset = 1'b1;
      req0 = 1'b0;
      tick();
      chk("rst_mem_write", mem_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack0", ack0, 0);
      reset = 1'b0;
      nack = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         nack += int'(ack0) + int'(ack1);
      end
      chk("rst_no_ack", nack, 0);
      chk("rst_mem_whole", (mem[12'hFF8 >> 1] == old) || (mem[12'hFF8 >> 1] == 16'hBBBB), 1);
      set_req(0, 1, 0, 12'hFF8, '0);
      set_req(1, 1, 0, 12'hFF8, '0);
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         if (ack0 || ack1) begin
            got = 1;
            chk("rst_first_tie", ack0, 1);
         end
      end
      chk("rst_tie_acked", got, 1);
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // One-cycle request pulse still completes with a single ack.
      set_req(1, 1, 0, 12'hFFE, '0);
      tick();
      req1 = 1'b0;
      nack = 0; t1 = -1;
      for (int i = 2; i <= 9; i++) begin
         tick();
         if (ack1) begin
            nack++;
            if (t1 < 0) t1 = i;
         end
      end
      chk("pulse_ack_count", nack, 1);
      chk("pulse_ack_time", t1, 3);
      chk("pulse_rdata", rdata1, 16'hAAAA);

      // Idle bus.
      nack = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         nack += int'(busy) + int'(mem_write) + int'(ack0) + int'(ack1);
      end
      chk("idle_quiet", nack, 0);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset = ($urandom_range(99) == 0);
         for (int r = 0; r < 2; r++) begin
            bit cur, ak;
            cur = r ? req1 : req0;
            ak  = r ? ack1 : ack0;
            if (cur && ak) begin
               if ($urandom_range(3) == 0)
                  set_req(r[0], 1, $urandom_range(1), 12'($urandom), 16'($urandom));
               else
                  set_req(r[0], 0, 0, '0, '0);
            end else if (cur) begin
               if ($urandom_range(15) == 0) set_req(r[0], 0, 0, '0, '0);
            end else if ($urandom_range(2) == 0) begin
               set_req(r[0], 1, $urandom_range(1), 12'($urandom), 16'($urandom));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
